// File: rtl/neuron_mac_seq_pkg.sv
// +----------------------------------------------------------------------------
// | neuron_mac_seq_pkg : shared FSM encoding and widths for the neuron MAC stage
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package neuron_mac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FINAL = 2'd3
  } state_e;

  // Matches the weight ROM read-port address width.
  localparam int ADDR_W        = 16;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_OUT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/neuron_mac_seq_if.sv
// +----------------------------------------------------------------------------
// | neuron_mac_seq_if : start/bias/ROM/result bundle for one neuron MAC stage
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface neuron_mac_seq_if
  import neuron_mac_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();

  logic                        start;
  logic signed [ACC_WIDTH-1:0] bias;
  logic [ADDR_W-1:0]           addr_rd;
  logic [WIDTH-1:0]            weight_in;
  logic [WIDTH-1:0]            act_in;
  logic                        busy;
  logic                        done;
  logic [OUT_WIDTH-1:0]        result;
  logic signed [ACC_WIDTH-1:0] acc_out;

  modport slave (
    input  start, bias, weight_in, act_in,
    output addr_rd, busy, done, result, acc_out
  );

  modport master (
    output start, bias, weight_in, act_in,
    input  addr_rd, busy, done, result, acc_out
  );

endinterface

`default_nettype wire

// File: rtl/neuron_mac_seq_relu_shift_sat.sv
// +----------------------------------------------------------------------------
// | relu_shift_sat : combinational ReLU, arithmetic right shift, unsigned saturate
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module relu_shift_sat #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic signed [IN_WIDTH-1:0] value_i,
  output logic [OUT_WIDTH-1:0]       result_o
);

  logic [IN_WIDTH-1:0] shifted;
  logic                ovf;

  assign shifted = value_i >>> SHIFT;
  assign ovf     = |shifted[IN_WIDTH-1:OUT_WIDTH];

  always_comb begin
    result_o = shifted[OUT_WIDTH-1:0];
    if (value_i[IN_WIDTH-1]) begin
      result_o = '0;
    end else if (ovf) begin
      result_o = '1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_mac_seq.sv
// +----------------------------------------------------------------------------
// | neuron_mac_seq : sequences weight ROM reads, accumulates the signed dot
// | product, then adds bias and applies ReLU/shift/saturate. Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module neuron_mac_seq
  import neuron_mac_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_INPUTS  = 784,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  neuron_mac_seq_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);
  localparam int                PROD_W    = 2 * WIDTH + 1;

  state_e                      state_q;
  logic [ADDR_W-1:0]           addr_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] bias_q;
  logic signed [ACC_WIDTH-1:0] acc_out_q;
  logic [OUT_WIDTH-1:0]        result_q;

  logic signed [PROD_W-1:0]    w_ext;
  logic signed [PROD_W-1:0]    a_ext;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0]        result_d;

  // Weight is signed, activation unsigned; one spare bit keeps the product exact.
  assign w_ext = {{(WIDTH + 1){bus.weight_in[WIDTH-1]}}, bus.weight_in};
  assign a_ext = {{(WIDTH + 1){1'b0}}, bus.act_in};
  assign prod  = w_ext * a_ext;
  assign acc_d = valid_q ? acc_q + {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod} : acc_q;
  assign sum   = acc_q + bias_q;

  relu_shift_sat #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_relu_shift_sat (
    .value_i  (sum),
    .result_o (result_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      bias_q    <= '0;
      acc_out_q <= '0;
      result_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      // ROM data arrives one cycle after its address, so the flag trails RUN.
      valid_q <= (state_q == ST_RUN);
      acc_q   <= acc_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            bias_q  <= bus.bias;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          acc_out_q <= sum;
          result_q  <= result_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          addr_q    <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.addr_rd = addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.acc_out = acc_out_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
// +----------------------------------------------------------------------------
// | tb_neuron_mac_seq : self-checking bench, two instances (SHIFT=0 and SHIFT=10)
// | Revision 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_neuron_mac_seq;

  localparam int N = 4;

  typedef struct packed {
    logic [3:0][7:0]    w;
    logic [3:0][7:0]    a;
    logic signed [31:0] bias;
    logic signed [31:0] acc;
    logic [7:0]         r0;
    logic [7:0]         r10;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic signed [7:0] wm [N];
  logic [7:0]        am [N];
  logic [7:0]        rom_w;
  logic [7:0]        rom_a;

  neuron_mac_seq_if #(.WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8)) ifa ();
  neuron_mac_seq_if #(.WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8)) ifb ();

  neuron_mac_seq #(.WIDTH(8), .N_INPUTS(N), .ACC_WIDTH(32), .SHIFT(0), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  neuron_mac_seq #(.WIDTH(8), .N_INPUTS(N), .ACC_WIDTH(32), .SHIFT(10), .OUT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency ROM shared by both instances.
  always @(posedge clk) begin
    rom_w <= wm[ifa.addr_rd[1:0]];
    rom_a <= am[ifa.addr_rd[1:0]];
  end

  assign ifa.weight_in = rom_w;
  assign ifa.act_in    = rom_a;
  assign ifb.weight_in = rom_w;
  assign ifb.act_in    = rom_a;
  assign ifb.start     = ifa.start;
  assign ifb.bias      = ifa.bias;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_sum(input longint b);
    longint s = b;
    for (int i = 0; i < N; i++) s += longint'(wm[i]) * longint'(am[i]);
    return s;
  endfunction

  function automatic longint model_res(input longint s, input int sh);
    longint r;
    if (s < 0) return 0;
    r = s >>> sh;
    return (r > 255) ? 255 : r;
  endfunction

  function automatic vec_t mk(input int w0, input int w1, input int w2, input int w3,
                              input int a, input int b, input int acc, input int r0,
                              input int r10);
    vec_t v;
    v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
    for (int i = 0; i < N; i++) v.a[i] = 8'(a);
    v.bias = b; v.acc = acc; v.r0 = 8'(r0); v.r10 = 8'(r10);
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) begin
      wm[i] = v.w[i];
      am[i] = v.a[i];
    end
  endtask

  // One full run: checks address sequence, latency, single-cycle done and results.
  task automatic do_run(input string tag, input logic signed [31:0] b, input longint exp_acc,
                        input longint exp_r0, input longint exp_r10, input int pulse_at);
    int cyc;
    bit seen;
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.bias  = b;
    @(negedge clk);
    ifa.start = 1'b0;
    check({tag, " busy"}, ifa.busy, 1);
    check({tag, " addr0"}, ifa.addr_rd, 0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      ifa.start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
      if (cyc <= N + 1) check($sformatf("%s addr%0d", tag, cyc), ifa.addr_rd, (cyc > N - 1) ? N - 1 : cyc);
      if (ifa.done) seen = 1;
    end
    ifa.start = 1'b0;
    check({tag, " latency"}, cyc, N + 2);
    check({tag, " done_b"}, ifb.done, 1);
    check({tag, " busy_done"}, ifa.busy, 0);
    check({tag, " acc_out"}, longint'($signed(ifa.acc_out)), exp_acc);
    check({tag, " result_s0"}, ifa.result, exp_r0);
    check({tag, " result_s10"}, ifb.result, exp_r10);
    @(negedge clk);
    check({tag, " done_pulse"}, ifa.done, 0);
  endtask

  vec_t vecs [6];
  int   done_cyc [$];

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    ifa.start = 1'b0;
    ifa.bias  = '0;
    for (int i = 0; i < N; i++) begin wm[i] = '0; am[i] = '0; end

    vecs[0] = mk(1, 2, 3, 4, 10, 0, 100, 100, 0);
    vecs[1] = mk(-1, -1, -1, -1, 10, 0, -40, 0, 0);
    vecs[2] = mk(127, 127, 127, 127, 255, 0, 129540, 255, 126);
    vecs[3] = mk(1, 2, 3, 4, 10, -100, 0, 0, 0);
    vecs[4] = mk(1, 2, 3, 4, 10, 27, 127, 127, 0);
    vecs[5] = mk(-128, -128, -128, -128, 255, 0, -130560, 0, 0);

    repeat (3) @(negedge clk);
    check("rst addr", ifa.addr_rd, 0);
    check("rst busy", ifa.busy, 0);
    check("rst done", ifa.done, 0);
    check("rst result", ifa.result, 0);
    check("rst acc_out", longint'($signed(ifa.acc_out)), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      load(vecs[k]);
      do_run($sformatf("vec%0d", k), vecs[k].bias, longint'(vecs[k].acc),
             longint'(vecs[k].r0), longint'(vecs[k].r10), -1);
    end

    // Mid-run start pulse must not disturb the address sequence or result.
    load(vecs[0]);
    do_run("midstart", 0, 100, 100, 0, 2);

    // Start held high: back-to-back runs accepted in each done cycle.
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.bias  = '0;
    done_cyc.delete();
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      if (ifa.done) done_cyc.push_back(c);
      if (c == 14) ifa.start = 1'b0;
    end
    check("hold done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("hold done1", done_cyc[0], 6);
      check("hold done2", done_cyc[1], 13);
      check("hold done3", done_cyc[2], 20);
    end
    check("hold result", ifa.result, 100);

    // Reset two edges after accept discards the previous result.
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst addr", ifa.addr_rd, 0);
    check("midrst busy", ifa.busy, 0);
    check("midrst done", ifa.done, 0);
    check("midrst result", ifa.result, 0);
    check("midrst acc_out", longint'($signed(ifa.acc_out)), 0);
    rst_n = 1'b1;
    begin
      int nd = 0;
      repeat (10) begin
        @(negedge clk);
        if (ifa.done) nd++;
      end
      check("midrst no_done", nd, 0);
    end
    do_run("after_rst", 0, 100, 100, 0, -1);

    // Randomised runs against the arithmetic model.
    for (int k = 0; k < 16; k++) begin
      longint s;
      int     b;
      for (int i = 0; i < N; i++) begin
        wm[i] = 8'($urandom);
        am[i] = 8'($urandom);
      end
      b = int'($urandom_range(140000, 0)) - 70000;
      s = model_sum(longint'(b));
      do_run($sformatf("rand%0d", k), b, s, model_res(s, 0), model_res(s, 10), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Sequencing and accumulate stage directly downstream of the weight ROM: computes one neuron output per run.
- Drives the ROM read address, consumes the 1-cycle-latency ROM data together with an address-aligned activation stream, and accumulates the signed dot product.
- Adds a bias, applies ReLU, then shifts and saturates.
- Result feeds the next layer's activation buffer; one instance per neuron.

Parameters:
- WIDTH, 8, bit width of weight and activation words (ROM WIDTH).
- N_INPUTS, 784, number of weight/activation pairs per neuron (ROM DEPTH).
- ACC_WIDTH, 32, accumulator width; signed; must be ≥ 2*WIDTH+clog2(N_INPUTS)+1.
- SHIFT, 0, right-shift applied after ReLU (fixed-point rescale).
- OUT_WIDTH, 8, result width; unsigned.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- bias  in  ACC_WIDTH  signed bias; sampled at the start-accept edge.
- addr_rd  out  16  read address to weight ROM and activation source.
- weight_in  in  WIDTH  signed two's-complement weight; ROM data for the address issued one cycle earlier.
- act_in  in  WIDTH  unsigned activation; same 1-cycle alignment as weight_in.
- busy  out  1  high from the accept edge until done.
- done  out  1  single-cycle pulse; result valid.
- result  out  OUT_WIDTH  activated, shifted, saturated output; held until next done.
- acc_out  out  ACC_WIDTH  raw acc+bias before ReLU, for debug; updated with result.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; addr_rd=0, busy=0, done=0, result=0, acc_out=0, accumulator=0, data-valid flag=0.
- FSM states: IDLE, RUN, DRAIN, FINAL.
- IDLE
  - addr_rd=0, busy=0.
  - start=1 at edge E0: latch bias, clear accumulator, enter RUN with addr_rd=0, busy=1.
- RUN
  - addr_rd increments by 1 each edge.
  - After the edge that presents N_INPUTS-1, the next edge enters DRAIN.
  - addr_rd never exceeds N_INPUTS-1; it holds there in DRAIN, then returns to 0 in IDLE.
- Valid flag
  - A 1-cycle delayed copy of "address issued" (high in RUN).
  - On an edge with the flag high: acc += sext(weight_in) * zext(act_in). Full-precision product, sign-extended to ACC_WIDTH.
  - The first product accumulates at edge E0+2; the last at the DRAIN→FINAL edge.
- DRAIN: 1 cycle; the last product accumulates.
- FINAL
  - 1 cycle. At its exit edge: s = acc + bias (ACC_WIDTH, wrap not expected given the width rule).
  - r = (s<0) ? 0 : s>>>SHIFT.
  - result = (r > 2^OUT_WIDTH-1) ? 2^OUT_WIDTH-1 : r.
  - acc_out = s; done=1 for one cycle; busy=0; state IDLE.
- Latency: done is high during the cycle following edge E0+N_INPUTS+2, i.e. N_INPUTS+2 edges after accept.
- start while busy: ignored, not queued.
- start high in the done cycle: accepted (state is IDLE), giving back-to-back runs with no bubble beyond FINAL.
- Reset mid-run: abort immediately to the reset values; no done pulse; the earlier result is discarded (result=0).
- Inputs outside valid-flag cycles: weight_in/act_in are don't-care.

Decomposition:
- Shared header/package
  - FSM state encodings (IDLE=0, RUN=1, DRAIN=2, FINAL=3).
  - Address width constant 16, shared with the ROM read port.
  - Default WIDTH/ACC_WIDTH.
- One natural sub-module: relu_shift_sat (combinational ReLU, shift, saturation from ACC_WIDTH to OUT_WIDTH), reused by every layer's neuron.
- The accumulator stays in this block.

Test Plan:
- Basic dot product: N_INPUTS=4, weights {1,2,3,4}, acts {10,10,10,10}, bias=0, start at E0.
  - addr_rd 0,1,2,3 on consecutive cycles; done at E0+6; result=100; acc_out=100.
- ReLU clamp: weights {-1,-1,-1,-1}, acts 10, bias=0.
  - acc_out=-40 (0xFFFFFFD8); result=0.
- Saturation and shift: weights 127, acts 255, N=4, bias=0.
  - SHIFT=0: acc_out=129540, result=255.
  - SHIFT=10: result=126.
- Bias: weights {1,2,3,4}, acts 10.
  - bias=-100: result=0.
  - bias=+27: result=127.
- Handshake: start held high across a whole run.
  - Exactly one done per N_INPUTS+3 cycles; the second run starts in the done cycle.
  - A start pulse mid-run is ignored (addr sequence unchanged).
- Reset mid-run: rst_n=0 at E0+2 with a prior result=100.
  - Next cycle: addr_rd=0, busy=0, result=0, no done.
  - A fresh run afterwards produces the correct value.
